key_schedule_seq: RTL and testbench

- Sequential, parametrised successor to the combinational AES-128 key expansion.
- Supports AES-128/192/256 (FIPS-197) through one parameter.
- Generates one 32-bit schedule word per clock and streams 128-bit round keys over a valid/ready interface with backpressure.
- Sits between the key-load logic and the round datapath, so round keys do not all have to be held in parallel.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/key_sched_word.sv | 33 +++
 rtl/key_schedule_seq.sv | 156 +++++++++++++++
 tb/tb_key_schedule_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES primitives for the key-schedule blocks: S-box, xtime, word type,
// FSM and word-phase encodings.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // How the next schedule word is derived from the window.
  typedef enum logic [1:0] {
    PH_KEY = 2'd0,
    PH_ROT = 2'd1,
    PH_SUB = 2'd2,
    PH_XOR = 2'd3
  } phase_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] base;
    base = {~a, 3'b000};
    return SBOX_TBL[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_sched_word.sv
// Combinational next-word function of the AES key expansion:
// w[i] = w[i-NK] ^ temp, temp selected by the word phase.
module key_sched_word
  import aes_pkg::*;
(
  input  logic [31:0] w_prev,
  input  logic [31:0] w_nk,
  input  logic [7:0]  rcon,
  input  logic [1:0]  phase,
  output logic [31:0] w_new
);

  phase_e ph;
  word_t  sub_in;
  word_t  sub_out;
  word_t  temp;

  always_comb begin
    ph      = phase_e'(phase);
    sub_in  = (ph == PH_ROT) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
               sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    // PH_KEY passes w_nk through untouched so key words flow out of the window.
    case (ph)
      PH_KEY:  temp = '0;
      PH_ROT:  temp = sub_out ^ {rcon, 24'h000000};
      PH_SUB:  temp = sub_out;
      default: temp = w_prev;
    endcase
    w_new = w_nk ^ temp;
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per clock,
// round keys streamed over a valid/ready interface with backpressure.
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int KEY_LEN = 128
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_LEN-1:0] key,
  input  logic               abort,
  output logic               ready,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [127:0]       rk_data,
  output logic [3:0]         rk_idx,
  output logic               done
);

  localparam int NK        = KEY_LEN / 32;
  localparam int NR        = NK + 6;
  localparam int LAST_WORD = 4 * (NR + 1) - 1;

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
    $error("key_schedule_seq: KEY_LEN must be 128, 192 or 256");
  end

  state_e       state_q, state_d;
  word_t        win_q [NK];
  word_t        win_d [NK];
  logic [5:0]   i_q, i_d;
  logic [2:0]   m_q, m_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [95:0]  asm_q, asm_d;
  logic         rk_valid_q, rk_valid_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]   rk_idx_q, rk_idx_d;

  phase_e phase;
  word_t  w_new;
  logic   advance;
  logic   hs;

  // Window holds w[i-NK] at index 0 and w[i-1] at index NK-1.
  key_sched_word u_word (
    .w_prev (win_q[NK-1]),
    .w_nk   (win_q[0]),
    .rcon   (rcon_q),
    .phase  (phase),
    .w_new  (w_new)
  );

  always_comb begin
    if (i_q < 6'(NK))                 phase = PH_KEY;
    else if (m_q == 3'd0)             phase = PH_ROT;
    else if (NK == 8 && m_q == 3'd4)  phase = PH_SUB;
    else                              phase = PH_XOR;
  end

  always_comb begin
    state_d    = state_q;
    for (int k = 0; k < NK; k++) win_d[k] = win_q[k];
    i_d        = i_q;
    m_d        = m_q;
    rcon_d     = rcon_q;
    asm_d      = asm_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    done       = 1'b0;

    hs      = rk_valid_q && rk_ready;
    advance = (state_q == EXPAND) && (!rk_valid_q || rk_ready);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXPAND;
          for (int k = 0; k < NK; k++) win_d[k] = key[KEY_LEN-1-32*k -: 32];
          i_d    = '0;
          m_d    = '0;
          rcon_d = RCON_INIT;
        end
      end
      EXPAND: begin
        if (hs) rk_valid_d = 1'b0;
        if (advance) begin
          // During the key phase the window rotates, so after NK words it
          // again holds w[0..NK-1] ready for the first derived word.
          for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
          win_d[NK-1] = w_new;
          i_d = i_q + 6'd1;
          m_d = (m_q == 3'(NK - 1)) ? 3'd0 : m_q + 3'd1;
          if (phase == PH_ROT) rcon_d = xtime(rcon_q);
          case (i_q[1:0])
            2'd0: asm_d[95:64] = w_new;
            2'd1: asm_d[63:32] = w_new;
            2'd2: asm_d[31:0]  = w_new;
            default: begin
              rk_data_d  = {asm_q, w_new};
              rk_idx_d   = i_q[5:2];
              rk_valid_d = 1'b1;
            end
          endcase
          if (i_q == 6'(LAST_WORD)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          rk_valid_d = 1'b0;
          state_d    = IDLE;
          done       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      rk_valid_d = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      i_q        <= '0;
      m_q        <= '0;
      rcon_q     <= RCON_INIT;
      asm_q      <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      for (int k = 0; k < NK; k++) win_q[k] <= win_d[k];
      i_q        <= i_d;
      m_q        <= m_d;
      rcon_q     <= rcon_d;
      asm_q      <= asm_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Scoreboard bench for key_schedule_seq: AES-128/192/256 instances driven with
// FIPS-197 vectors, backpressure, abort and mid-run reset.
module tb_key_schedule_seq;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [2:0]            start = '0;
  logic [2:0]            abort = '0;
  logic [2:0]            rk_ready = '1;
  logic [2:0][255:0]     key_bus = '0;
  logic [2:0]            ready;
  logic [2:0]            rk_valid;
  logic [2:0][127:0]     rk_data;
  logic [2:0][3:0]       rk_idx;
  logic [2:0]            done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int           inst;
    logic [3:0]   idx;
    logic [127:0] data;
    bit           chk;
  } exp_t;
  exp_t sbq[$];

  logic [127:0] aes128_rk [11];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KL = 128 + 64 * g;
    key_schedule_seq #(.KEY_LEN(KL)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .key      (key_bus[g][255 -: KL]),
      .abort    (abort[g]),
      .ready    (ready[g]),
      .rk_valid (rk_valid[g]),
      .rk_ready (rk_ready[g]),
      .rk_data  (rk_data[g]),
      .rk_idx   (rk_idx[g]),
      .done     (done[g])
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int inst, input int idx, input logic [127:0] data, input bit c);
    exp_t e;
    e.inst = inst;
    e.idx  = 4'(idx);
    e.data = data;
    e.chk  = c;
    sbq.push_back(e);
  endtask

  task automatic start_run(input int g, input logic [255:0] k);
    key_bus[g] = k;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  task automatic run_to_done(input int g, input bit rand_rdy, input bit mid_start);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (sbq.size() == 0 && ready[g]) begin
        ok = 1'b1;
        break;
      end
      rk_ready[g] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start[g] = mid_start && (n == 12);
      if (mid_start && n == 12) begin
        key_bus[g] = {256{1'b1}};
        chk("busy_ready_low", ready[g], 0);
      end
      tick();
    end
    start[g] = 1'b0;
    rk_ready[g] = 1'b1;
    chk("run_complete", ok, 1);
  endtask

  // Monitor: pops the scoreboard on every accepted round key.
  bit [2:0]     prev_stall = '0;
  bit [2:0]     prev_abort = '0;
  logic [127:0] prev_data [3];
  logic [3:0]   prev_idx [3];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = '0;
        prev_abort = '0;
      end else begin
        for (int g = 0; g < 3; g++) begin
          if (prev_stall[g] && !prev_abort[g]) begin
            chk("hold_valid", rk_valid[g], 1);
            chk("hold_data", rk_data[g], prev_data[g]);
            chk("hold_idx", rk_idx[g], prev_idx[g]);
          end
          if (rk_valid[g] && rk_ready[g] && !abort[g]) begin
            if (sbq.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_underflow inst=%0d actual_idx=%0d required=no_key", g, rk_idx[g]);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              chk("sb_inst", g, e.inst);
              chk("sb_idx", rk_idx[g], e.idx);
              if (e.chk) chk("sb_data", rk_data[g], e.data);
              chk("sb_done", done[g], (e.idx == 4'(10 + 2 * g)));
            end
          end else begin
            chk("done_idle", done[g], 0);
          end
          prev_stall[g] = rk_valid[g] && !rk_ready[g];
          prev_abort[g] = abort[g];
          prev_data[g]  = rk_data[g];
          prev_idx[g]   = rk_idx[g];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k128, k192, k256;
    bit found;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    aes128_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    aes128_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    aes128_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    aes128_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    aes128_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    aes128_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    aes128_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    aes128_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    aes128_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    aes128_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    aes128_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      chk("rst_ready", ready[g], 1);
      chk("rst_valid", rk_valid[g], 0);
      chk("rst_data", rk_data[g], 0);
      chk("rst_idx", rk_idx[g], 0);
      chk("rst_done", done[g], 0);
    end
    rst = 1'b0;
    tick();

    // AES-128 with latency checks
    for (int r = 0; r < 11; r++) push(0, r, aes128_rk[r], 1'b1);
    key_bus[0] = k128;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (3) tick();
    chk("lat_e3_valid", rk_valid[0], 0);
    tick();
    chk("lat_e4_valid", rk_valid[0], 1);
    chk("lat_e4_idx", rk_idx[0], 0);
    chk("lat_e4_data", rk_data[0], aes128_rk[0]);
    repeat (4) tick();
    chk("lat_e8_idx", rk_idx[0], 1);
    chk("lat_e8_data", rk_data[0], aes128_rk[1]);
    repeat (36) tick();
    chk("lat_e44_valid", rk_valid[0], 1);
    chk("lat_e44_idx", rk_idx[0], 10);
    chk("lat_e44_data", rk_data[0], aes128_rk[10]);
    chk("lat_e44_done", done[0], 1);
    tick();
    chk("lat_e45_ready", ready[0], 1);
    chk("lat_e45_valid", rk_valid[0], 0);
    chk("sb_empty_128", sbq.size(), 0);

    // AES-192
    push(1, 0, 128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1);
    push(1, 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b1);
    for (int r = 2; r < 12; r++) push(1, r, '0, 1'b0);
    push(1, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b1);
    start_run(1, k192);
    run_to_done(1, 1'b0, 1'b0);

    // AES-256, including the i%8==4 SubWord word in round key 3
    push(2, 0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b1);
    push(2, 1, 128'h1f352c073b6108d72d9810a30914dff4, 1'b1);
    push(2, 2, 128'h9ba354118e6925afa51a8b5f2067fcde, 1'b1);
    push(2, 3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a, 1'b1);
    for (int r = 4; r < 14; r++) push(2, r, '0, 1'b0);
    push(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1);
    start_run(2, k256);
    run_to_done(2, 1'b0, 1'b0);

    // AES-128 under random backpressure with an ignored start while busy
    for (int r = 0; r < 11; r++) push(0, r, aes128_rk[r], 1'b1);
    start_run(0, k128);
    run_to_done(0, 1'b1, 1'b1);

    // Abort while round key 3 is presented
    for (int r = 0; r < 3; r++) push(0, r, aes128_rk[r], 1'b1);
    start_run(0, k128);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rk_valid[0] && rk_idx[0] == 4'd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reach_idx3", found, 1);
    abort[0] = 1'b1;
    rk_ready[0] = 1'b0;
    tick();
    abort[0] = 1'b0;
    rk_ready[0] = 1'b1;
    chk("abort_ready", ready[0], 1);
    chk("abort_valid", rk_valid[0], 0);
    chk("abort_sb_empty", sbq.size(), 0);
    tick();
    chk("abort_done_low", done[0], 0);
    for (int r = 0; r < 11; r++) push(0, r, aes128_rk[r], 1'b1);
    start_run(0, k128);
    run_to_done(0, 1'b0, 1'b0);

    // Asynchronous reset mid-expansion, then a clean restart
    push(0, 0, aes128_rk[0], 1'b1);
    start_run(0, k128);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready[0], 1);
    chk("mid_rst_valid", rk_valid[0], 0);
    chk("mid_rst_data", rk_data[0], 0);
    chk("mid_rst_idx", rk_idx[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_sb_empty", sbq.size(), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < 11; r++) push(0, r, aes128_rk[r], 1'b1);
    start_run(0, k128);
    run_to_done(0, 1'b0, 1'b0);

    tick();
    chk("final_sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
